tx_slv_master: RTL and testbench
================================

# tx_slv_master

Transmit-side master for the PPE tx slave interface. It accepts packet words from the upstream PPE pipeline through a valid/ready port, buffers them in a small FIFO and presents them to the downstream tx slave using the `en`/`rdy` handshake. The handshake runs on the master side of the interface: `en` is an output and `rdy` is an input. The block also enforces an inter-packet gap and flags a slave that stalls too long.

## Interface

**Parameters**
- `DW`, 32: data width.
- `DEPTH`, 8: FIFO depth. Must be a power of 2 and ≥ 2.
- `IPG`, 2: idle cycles forced after each accepted EOP word. 0 disables the gap.
- `TIMEOUT`, 256: consecutive stalled cycles before `timeout_err`. Must be ≥ 1.
- `CW`, 16: width of `pkt_cnt`.

**Ports**
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: FIFO can accept a word.
- `in_data` in DW: upstream data.
- `in_sop` in 1: first word of packet.
- `in_eop` in 1: last word of packet.
- `tx_en` out 1: word presented to slave (async_en).
- `tx_rdy` in 1: slave accepts word (async_rdy).
- `tx_data` out DW: data to slave.
- `tx_sop` out 1: SOP to slave.
- `tx_eop` out 1: EOP to slave.
- `pkt_cnt` out CW: packets fully transferred. Wraps.
- `timeout_err` out 1: one-cycle pulse on stall timeout.

## Operation

- **Upstream push**: a word is pushed when `in_valid && in_ready`. `in_ready = !full`. A full FIFO refuses push even if a pop occurs in the same cycle.
- **Downstream transfer**: a word transfers when `tx_en && tx_rdy` at a posedge. The FIFO pops on that edge.
- **`tx_data`/`tx_sop`/`tx_eop`**: always equal the FIFO head. They are don't-care while `tx_en = 0`.
- **FSM states**: IDLE, XFER, GAP.
  - IDLE: `tx_en = 0`. Go to XFER when the FIFO is non-empty.
  - XFER: `tx_en = !empty`.
    - Transfer of an EOP word with `IPG > 0`: go to GAP and load the gap counter with `IPG`.
    - Transfer of an EOP word with `IPG = 0`: stay in XFER.
    - FIFO becomes empty: go to IDLE.
  - GAP: `tx_en = 0`. The counter decrements each cycle. At 1, go to XFER if non-empty, else IDLE. Exactly `IPG` idle cycles occur.
- **Presentation rule**: once `tx_en` rises, it and `tx_data`/`tx_sop`/`tx_eop` hold stable until the transfer cycle. The master never withdraws a word.
- **Packet counter**: `pkt_cnt` increments on every EOP transfer and wraps at 2^CW. Framing errors (missing SOP/EOP) are passed through unchanged and are not checked.
- **Stall counter**: increments on cycles with `tx_en && !tx_rdy`. It clears on a transfer or when `tx_en = 0`.
  - When the count reaches `TIMEOUT`, `timeout_err` pulses for one cycle and the counter clears.
  - The word keeps being presented, so the pulse repeats every `TIMEOUT` stalled cycles.
- **FIFO pointers**: `$clog2(DEPTH)+1` bits wide, with wrap-bit full/empty detection. Occupancy never exceeds `DEPTH`.

## Timing

- **Reset values**: `in_ready = 1` (empty FIFO), `tx_en = 0`, `tx_data`/`tx_sop`/`tx_eop = 0` (head entry reset), `pkt_cnt = 0`, `timeout_err = 0`. FSM = IDLE, stall and gap counters = 0.
- **Latency**: a word pushed at edge N into an empty FIFO while in IDLE gives `tx_en = 1` in the cycle after edge N+1. IDLE→XFER registers at N+1, so latency is 2 edges.
  - In XFER with words queued, back-to-back transfers occur at one word per cycle while `tx_rdy = 1`.
- **Reset mid-operation**: `rst` at an edge discards all FIFO content and any in-flight word. `tx_en` drops in the next cycle and counters clear. No `timeout_err` is generated on reset.
- **`in_ready` timing**: registered from occupancy. It reasserts the cycle after a pop from full.
- **`timeout_err` timing**: asserts in the cycle following the `TIMEOUT`-th stalled edge.

## Structure

- **Package `tx_slv_pkg`**:
  - FSM state enum `tx_mst_state_e` {IDLE, XFER, GAP}.
  - FIFO entry struct `tx_word_t` {data, sop, eop}, parameterised via `DW` localparam default.
  - Default constants for `IPG` and `TIMEOUT`.
- **Sub-module `tx_slv_fifo`**: synchronous FIFO of `tx_word_t`, `DEPTH` entries, ports push/pop/full/empty/head.
- **Top level**: contains the FSM, gap counter, stall counter and `pkt_cnt`.

## Test plan

- **Reset then one 3-word packet, `tx_rdy = 1`**: SOP/EOP correct, 3 consecutive transfers, then `tx_en` low for 2 cycles with `IPG = 2`. `pkt_cnt = 1`.
- **Push 8 words with `tx_rdy = 0`**: `in_ready` drops after the 8th push and the 9th word is refused. Raising `tx_rdy` drains all 8 in order, and `in_ready` returns 1 cycle after the first pop.
- **`tx_rdy` toggling randomly 50%**: `tx_data` is stable while `tx_en && !tx_rdy`, and the output data sequence equals the input sequence.
- **`TIMEOUT = 4`, `tx_rdy` held 0 for 10 cycles**: `timeout_err` pulses exactly twice, 4 cycles apart. The word is then transferred when `rdy` rises.
- **`rst` asserted mid-packet with 5 words queued**: the next cycle shows `tx_en = 0` and `in_ready = 1`, and `pkt_cnt` is 0. New traffic after reset transfers normally.
- **`CW = 2`, send 5 single-word packets with `IPG = 0`**: transfers are back-to-back without gaps, and `pkt_cnt` wraps to 1.

Source files
------------

// File: rtl/tx_slv_pkg.sv
// tx_slv_pkg: shared types and default constants for the PPE tx slave master.
package tx_slv_pkg;

    // Default data width used by the stock FIFO entry type.
    localparam int TX_DW = 32;

    // Default idle cycles forced after each EOP transfer.
    localparam int DEFAULT_IPG = 2;

    // Default consecutive stalled cycles before a timeout pulse.
    localparam int DEFAULT_TIMEOUT = 256;

    // Master handshake state.
    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } tx_mst_state_e;

    // One buffered packet word with its framing flags.
    typedef struct packed {
        logic [TX_DW-1:0] data;
        logic             sop;
        logic             eop;
    } tx_word_t;

endpackage

// File: rtl/tx_slv_fifo.sv
// tx_slv_fifo: synchronous FIFO of packet words. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module tx_slv_fifo import tx_slv_pkg::*; #(
    parameter int  DEPTH = 8,
    parameter type T     = tx_word_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  T                         push_word_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output T                         head_o
);

    localparam int AW = $clog2(DEPTH);

    T             mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Storage: cleared on reset so the presented head reads as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_word_i;
        end
    end

    // Read and write pointers with wrap bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/tx_slv_master.sv
// tx_slv_master: buffers upstream packet words and presents them to the tx
// slave over en/rdy, enforcing an inter-packet gap and flagging long stalls.
module tx_slv_master import tx_slv_pkg::*; #(
    parameter int DW      = TX_DW,
    parameter int DEPTH   = 8,
    parameter int IPG     = DEFAULT_IPG,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_sop,
    input  logic          in_eop,
    output logic          tx_en,
    input  logic          tx_rdy,
    output logic [DW-1:0] tx_data,
    output logic          tx_sop,
    output logic          tx_eop,
    output logic [CW-1:0] pkt_cnt,
    output logic          timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (IPG > 0) ? $clog2(IPG + 1) : 1;
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } word_t;

    word_t          push_word;
    word_t          head;
    logic           full;
    logic           empty;
    logic [AW:0]    count;
    logic           push;
    logic           xfer;
    logic           more_nxt;

    tx_mst_state_e  state_q;
    logic           tx_en_q;
    logic [GW-1:0]  gap_q;
    logic [SW-1:0]  stall_q;
    logic           err_q;
    logic [CW-1:0]  pkt_q;

    assign push_word = '{data: in_data, sop: in_sop, eop: in_eop};
    assign push      = in_valid && !full;
    assign xfer      = tx_en_q && tx_rdy;
    // FIFO still holds a word after this edge's push/pop.
    assign more_nxt  = push || (count > {{AW{1'b0}}, xfer});

    tx_slv_fifo #(
        .DEPTH (DEPTH),
        .T     (word_t)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_word_i (push_word),
        .pop_i       (xfer),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count),
        .head_o      (head)
    );

    assign in_ready    = !full;
    assign tx_en       = tx_en_q;
    assign tx_data     = head.data;
    assign tx_sop      = head.sop;
    assign tx_eop      = head.eop;
    assign pkt_cnt     = pkt_q;
    assign timeout_err = err_q;

    // Handshake FSM; tx_en is registered and only drops after a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_en_q <= 1'b0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q <= XFER;
                        tx_en_q <= 1'b1;
                    end
                end
                XFER: begin
                    if (xfer && head.eop && (IPG > 0)) begin
                        state_q <= GAP;
                        tx_en_q <= 1'b0;
                        gap_q   <= GW'(IPG);
                    end else if (!more_nxt) begin
                        state_q <= IDLE;
                        tx_en_q <= 1'b0;
                    end else begin
                        tx_en_q <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GW'(1)) begin
                        gap_q <= '0;
                        if (!empty) begin
                            state_q <= XFER;
                            tx_en_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_en_q <= 1'b0;
                    gap_q   <= '0;
                end
            endcase
        end
    end

    // Stall watchdog: pulses every TIMEOUT consecutive stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else if (tx_en_q && !tx_rdy) begin
            if (stall_q == SW'(TIMEOUT - 1)) begin
                stall_q <= '0;
                err_q   <= 1'b1;
            end else begin
                stall_q <= stall_q + SW'(1);
                err_q   <= 1'b0;
            end
        end else begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end
    end

    // Completed-packet counter, wrapping naturally at 2^CW.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_q <= '0;
        end else if (xfer && head.eop) begin
            pkt_q <= pkt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_tx_slv_master.sv
// tb_tx_slv_master: directed tables, hand sequences and a randomized
// scoreboard run against two configurations of tx_slv_master.
module tb_tx_slv_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: IPG=2, TIMEOUT=4, CW=16
    logic        a_rst, a_in_valid, a_in_ready, a_in_sop, a_in_eop;
    logic        a_tx_en, a_tx_rdy, a_tx_sop, a_tx_eop, a_err;
    logic [31:0] a_in_data, a_tx_data;
    logic [15:0] a_pkt;

    // Instance B: IPG=0, CW=2
    logic        b_rst, b_in_valid, b_in_ready, b_in_sop, b_in_eop;
    logic        b_tx_en, b_tx_rdy, b_tx_sop, b_tx_eop, b_err;
    logic [31:0] b_in_data, b_tx_data;
    logic [1:0]  b_pkt;

    tx_slv_master #(.DW(32), .DEPTH(8), .IPG(2), .TIMEOUT(4), .CW(16)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_sop(a_in_sop), .in_eop(a_in_eop),
        .tx_en(a_tx_en), .tx_rdy(a_tx_rdy), .tx_data(a_tx_data),
        .tx_sop(a_tx_sop), .tx_eop(a_tx_eop), .pkt_cnt(a_pkt), .timeout_err(a_err)
    );

    tx_slv_master #(.DW(32), .DEPTH(8), .IPG(0), .TIMEOUT(256), .CW(2)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_sop(b_in_sop), .in_eop(b_in_eop),
        .tx_en(b_tx_en), .tx_rdy(b_tx_rdy), .tx_data(b_tx_data),
        .tx_sop(b_tx_sop), .tx_eop(b_tx_eop), .pkt_cnt(b_pkt), .timeout_err(b_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_rst      = 1'b1;
        a_in_valid = 1'b0;
        step();
        step();
        a_rst = 1'b0;
    endtask

    // Directed vector: inputs before an edge, expected outputs after it.
    typedef struct {
        logic        vld, sop, eop;
        logic [31:0] dat;
        logic        rdy;
        logic        een, esop, eeop;
        logic [31:0] edat;
        logic [15:0] ecnt;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic s, input logic e,
                                input logic [31:0] d, input logic r,
                                input logic xen, input logic xs, input logic xe,
                                input logic [31:0] xd, input logic [15:0] xc);
        vec_t t;
        t.vld = v; t.sop = s; t.eop = e; t.dat = d; t.rdy = r;
        t.een = xen; t.esop = xs; t.eeop = xe; t.edat = xd; t.ecnt = xc;
        return t;
    endfunction

    // Scoreboard model: words in flight form a queue; the slave side must
    // deliver them in order, hold a stalled word, and pulse on long stalls.
    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } wd_t;

    wd_t sb[$];
    bit  mon_on     = 1'b0;
    bit  prev_stall = 1'b0;
    wd_t prev_w;
    int  stall_run  = 0;
    bit  err_pend   = 1'b0;
    int  eop_pushed = 0;

    always @(negedge clk) begin
        wd_t cur;
        wd_t exp_w;
        if (mon_on) begin
            cur = {a_tx_data, a_tx_sop, a_tx_eop};
            chk("rnd_in_ready", 64'(a_in_ready), 64'(sb.size() < 8));
            if (prev_stall) begin
                chk("rnd_hold_en", 64'(a_tx_en), 64'(1'b1));
                chk("rnd_hold_word", 64'(cur), 64'(prev_w));
            end
            chk("rnd_timeout_err", 64'(a_err), 64'(err_pend));
            if (a_tx_en && !a_tx_rdy) begin
                stall_run++;
                err_pend = (stall_run == 4);
                if (err_pend) stall_run = 0;
            end else begin
                stall_run = 0;
                err_pend  = 1'b0;
            end
            if (a_tx_en && a_tx_rdy) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rnd_xfer: actual transfer of %0h, required no transfer (nothing queued)", a_tx_data);
                end else begin
                    exp_w = sb.pop_front();
                    chk("rnd_xfer_word", 64'(cur), 64'(exp_w));
                end
            end
            if (a_in_valid && a_in_ready) begin
                sb.push_back({a_in_data, a_in_sop, a_in_eop});
                if (a_in_eop) eop_pushed++;
            end
            prev_stall = a_tx_en && !a_tx_rdy;
            prev_w     = cur;
        end
    end

    vec_t tv[9];
    int   ngot, npulse, p1, p2;
    bit   first_chk;

    initial begin
        a_rst = 1'b1; a_in_valid = 1'b0; a_in_sop = 1'b0; a_in_eop = 1'b0;
        a_in_data = '0; a_tx_rdy = 1'b0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_sop = 1'b0; b_in_eop = 1'b0;
        b_in_data = '0; b_tx_rdy = 1'b0;

        tv[0] = mk(1'b1, 1'b1, 1'b0, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  16'd0);
        tv[1] = mk(1'b1, 1'b0, 1'b0, 32'hA1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA0, 16'd0);
        tv[2] = mk(1'b1, 1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA1, 16'd0);
        tv[3] = mk(1'b1, 1'b1, 1'b1, 32'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA2, 16'd0);
        tv[4] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  16'd1);
        tv[5] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  16'd1);
        tv[6] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 32'hA3, 16'd1);
        tv[7] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  16'd2);
        tv[8] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  16'd2);

        step();
        step();

        // Reset state of both instances
        chk("rst_a_in_ready", 64'(a_in_ready), 64'(1'b1));
        chk("rst_a_tx_en",    64'(a_tx_en),    64'(1'b0));
        chk("rst_a_head",     64'({a_tx_data, a_tx_sop, a_tx_eop}), 64'(0));
        chk("rst_a_pkt",      64'(a_pkt),      64'(0));
        chk("rst_a_err",      64'(a_err),      64'(1'b0));
        chk("rst_b_in_ready", 64'(b_in_ready), 64'(1'b1));
        chk("rst_b_tx_en",    64'(b_tx_en),    64'(1'b0));
        chk("rst_b_head",     64'({b_tx_data, b_tx_sop, b_tx_eop}), 64'(0));
        chk("rst_b_pkt",      64'(b_pkt),      64'(0));
        a_rst = 1'b0;

        // 3-word packet then a 1-word packet, rdy=1, IPG=2
        for (int i = 0; i < 9; i++) begin
            a_in_valid = tv[i].vld; a_in_sop = tv[i].sop; a_in_eop = tv[i].eop;
            a_in_data  = tv[i].dat; a_tx_rdy = tv[i].rdy;
            step();
            chk($sformatf("t1_en[%0d]", i),       64'(a_tx_en),    64'(tv[i].een));
            chk($sformatf("t1_in_ready[%0d]", i), 64'(a_in_ready), 64'(1'b1));
            chk($sformatf("t1_pkt[%0d]", i),      64'(a_pkt),      64'(tv[i].ecnt));
            chk($sformatf("t1_err[%0d]", i),      64'(a_err),      64'(1'b0));
            if (tv[i].een) begin
                chk($sformatf("t1_word[%0d]", i), 64'({a_tx_data, a_tx_sop, a_tx_eop}),
                    64'({tv[i].edat, tv[i].esop, tv[i].eeop}));
            end
        end

        // Fill to full with rdy=0, refuse the 9th, then drain in order
        reset_a();
        a_tx_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1; a_in_data = 32'hD000_0000 + i;
            a_in_sop = (i == 0); a_in_eop = (i == 7);
            step();
            chk($sformatf("t2_fill_in_ready[%0d]", i), 64'(a_in_ready), 64'(i < 7));
        end
        a_in_valid = 1'b1; a_in_data = 32'hDEAD_BEEF; a_in_sop = 1'b0; a_in_eop = 1'b0;
        step();
        chk("t2_full_refuse", 64'(a_in_ready), 64'(1'b0));
        a_in_valid = 1'b0;
        a_tx_rdy   = 1'b1;
        ngot = 0;
        first_chk = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (a_tx_en) begin
                if (ngot < 8) begin
                    chk($sformatf("t2_drain_word[%0d]", ngot), 64'(a_tx_data), 64'(32'hD000_0000 + ngot));
                end else begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL t2_extra_word: actual %0h, required no 9th transfer", a_tx_data);
                end
                ngot++;
            end
            step();
            if (first_chk && ngot == 1) begin
                chk("t2_in_ready_after_pop", 64'(a_in_ready), 64'(1'b1));
                first_chk = 1'b0;
            end
        end
        chk("t2_drain_count", 64'(ngot), 64'(8));
        chk("t2_pkt", 64'(a_pkt), 64'(1));

        // Stall timeout with TIMEOUT=4 over 10 stalled cycles
        reset_a();
        a_tx_rdy = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h7777_0001; a_in_sop = 1'b1; a_in_eop = 1'b1;
        step();
        a_in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (!a_tx_en) step();
        end
        chk("t4_present", 64'(a_tx_en), 64'(1'b1));
        npulse = 0; p1 = 0; p2 = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (a_err) begin
                npulse++;
                if (npulse == 1) p1 = k;
                else p2 = k;
            end
        end
        chk("t4_pulses", 64'(npulse), 64'(2));
        chk("t4_first_pulse", 64'(p1), 64'(4));
        chk("t4_second_pulse", 64'(p2), 64'(8));
        chk("t4_held_en", 64'(a_tx_en), 64'(1'b1));
        chk("t4_held_word", 64'(a_tx_data), 64'(32'h7777_0001));
        a_tx_rdy = 1'b1;
        step();
        chk("t4_xfer_en", 64'(a_tx_en), 64'(1'b0));
        chk("t4_xfer_pkt", 64'(a_pkt), 64'(1));

        // Reset with 5 words queued mid-packet (stall about to time out)
        a_tx_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1; a_in_data = 32'h5500_0000 + i;
            a_in_sop = (i == 0); a_in_eop = 1'b0;
            step();
        end
        a_in_valid = 1'b0;
        a_rst = 1'b1;
        step();
        chk("t5_en", 64'(a_tx_en), 64'(1'b0));
        chk("t5_in_ready", 64'(a_in_ready), 64'(1'b1));
        chk("t5_pkt", 64'(a_pkt), 64'(0));
        chk("t5_err", 64'(a_err), 64'(1'b0));
        a_rst = 1'b0;
        step();
        chk("t5_err_after", 64'(a_err), 64'(1'b0));
        chk("t5_en_after", 64'(a_tx_en), 64'(1'b0));
        a_tx_rdy = 1'b1;
        a_in_valid = 1'b1; a_in_data = 32'h600D_0001; a_in_sop = 1'b1; a_in_eop = 1'b1;
        step();
        a_in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (!a_tx_en) step();
        end
        chk("t5_new_en", 64'(a_tx_en), 64'(1'b1));
        chk("t5_new_word", 64'(a_tx_data), 64'(32'h600D_0001));
        step();
        chk("t5_new_pkt", 64'(a_pkt), 64'(1));

        // Randomized traffic with 50% rdy against the scoreboard
        reset_a();
        sb.delete();
        stall_run = 0; err_pend = 1'b0; prev_stall = 1'b0; eop_pushed = 0;
        mon_on = 1'b1;
        for (int c = 0; c < 400; c++) begin
            a_in_valid = 1'($urandom_range(0, 1));
            a_in_data  = $urandom;
            a_in_sop   = ($urandom_range(0, 3) == 0);
            a_in_eop   = ($urandom_range(0, 3) == 0);
            a_tx_rdy   = 1'($urandom_range(0, 1));
            step();
        end
        a_in_valid = 1'b0;
        a_tx_rdy   = 1'b1;
        for (int c = 0; c < 60; c++) step();
        mon_on = 1'b0;
        chk("rnd_all_delivered", 64'(sb.size()), 64'(0));
        chk("rnd_pkt", 64'(a_pkt), 64'(eop_pushed[15:0]));

        // IPG=0, CW=2: 5 single-word packets back-to-back, counter wraps
        b_rst = 1'b0;
        b_tx_rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                b_in_valid = 1'b1; b_in_data = 32'hB0 + k; b_in_sop = 1'b1; b_in_eop = 1'b1;
            end else begin
                b_in_valid = 1'b0;
            end
            step();
            if (k >= 1 && k <= 5) begin
                chk($sformatf("t6_en[%0d]", k), 64'(b_tx_en), 64'(1'b1));
                chk($sformatf("t6_word[%0d]", k), 64'(b_tx_data), 64'(32'hB0 + k - 1));
            end
            if (k == 5) chk("t6_pkt_wrap0", 64'(b_pkt), 64'(0));
        end
        chk("t6_en_end", 64'(b_tx_en), 64'(1'b0));
        chk("t6_pkt_wrap1", 64'(b_pkt), 64'(1));
        chk("t6_err", 64'(b_err), 64'(1'b0));
        chk("t6_in_ready", 64'(b_in_ready), 64'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
